// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// Holds the arbiter FSM state encoding and the bus transfer size codes.
// Imported by mem_bus_arbiter and by anything that drives or decodes bus_size.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates IF fetches and MEM loads/stores onto one shared bus, one transaction at a time.
// Latency: request seen in IDLE cycle N -> bus_req at N+1 -> done pulse at N+2 at the earliest.
// Backpressure: bus_req held until bus_addr_ok, then waits for bus_data_ok; requesters stall meanwhile.
// Ports: inst_* (fetch side), data_* (load/store side), flush (from ctrl), bus_* (shared slave),
//        stallreq_from_if/stallreq_from_mem (to ctrl), perf_txn (completed transaction count).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stallreq_from_if,
    output logic              stallreq_from_mem,
    output logic [15:0]       perf_txn
);

    arb_state_t        state;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [DATA_W-1:0] lat_wdata;
    logic              discard;
    logic [15:0]       txn_cnt;

    logic in_data;
    logic bus_done;

    // Handshakes arriving in the wrong phase are ignored by qualifying with state.
    assign in_data  = (state == I_DATA) || (state == D_DATA);
    assign bus_done = in_data && bus_data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_wdata <= '0;
            discard   <= 1'b0;
            txn_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    // MEM side wins a tie: the load/store is older in program order.
                    if (data_req) begin
                        state     <= D_ADDR;
                        lat_addr  <= data_addr;
                        lat_wr    <= data_wr;
                        lat_size  <= data_size;
                        lat_wdata <= data_wdata;
                    end else if (inst_req && !flush) begin
                        state     <= I_ADDR;
                        lat_addr  <= inst_addr;
                        lat_wr    <= 1'b0;
                        lat_size  <= SZ_WORD;
                        lat_wdata <= '0;
                    end
                end
                I_ADDR: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (bus_addr_ok) begin
                        state <= I_DATA;
                    end
                end
                I_DATA: begin
                    // A flushed fetch still runs to completion on the bus; only its result is dropped.
                    if (bus_data_ok) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                D_ADDR: begin
                    if (bus_addr_ok) begin
                        state <= D_DATA;
                    end
                end
                D_DATA: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (bus_done) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end

    assign bus_req   = (state == I_ADDR) || (state == D_ADDR);
    assign bus_wr    = lat_wr;
    assign bus_size  = lat_size;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;

    // A flush landing in the completing cycle itself must also suppress the fetch result.
    assign inst_done = (state == I_DATA) && bus_data_ok && !discard && !flush;
    assign data_done = (state == D_DATA) && bus_data_ok;

    // Read data is steered only to the side that owns the bus, so both are zero when idle or in reset.
    assign inst_rdata = (state == I_DATA) ? bus_rdata : '0;
    assign data_rdata = (state == D_DATA) ? bus_rdata : '0;

    assign stallreq_from_mem = data_req && !data_done;
    assign stallreq_from_if  = inst_req && !inst_done && !flush;

    assign perf_txn = txn_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic [DW-1:0] inst_rdata;
    logic          inst_done;
    logic          data_req = 1'b0;
    logic          data_wr = 1'b0;
    logic [1:0]    data_size = 2'd0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata;
    logic          data_done;
    logic          flush = 1'b0;
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok = 1'b0;
    logic          bus_data_ok = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          stallreq_from_if;
    logic          stallreq_from_mem;
    logic [15:0]   perf_txn;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
        .flush(flush),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
        .perf_txn(perf_txn)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // kind: 0 fetch, 1 load, 2 store
    typedef struct {
        int          kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    size;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic exp_t mk_exp(input int kind, input logic [AW-1:0] a,
                                    input logic [DW-1:0] wd, input logic [1:0] sz);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = (kind == 2) ? wd : mem_word(a);
        e.size = (kind == 0) ? SZ_WORD : sz;
        return e;
    endfunction

    // Bus slave: accepts an address after addr_dly waiting cycles, completes data_dly cycles later.
    int            addr_dly = 0;
    int            data_dly = 0;
    int            wcnt = 0;
    int            dcnt = 0;
    bit            pending = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic          acc_wr = 1'b0;
    logic [1:0]    acc_size = '0;
    logic [DW-1:0] acc_wdata = '0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            pending     = 1'b0;
            wcnt        = 0;
            dcnt        = 0;
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = '0;
        end else begin
            bus_data_ok = 1'b0;
            bus_rdata   = '0;
            if (bus_addr_ok) begin
                pending = 1'b1;
                dcnt    = 0;
            end
            bus_addr_ok = 1'b0;
            if (pending) begin
                if (dcnt >= data_dly) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = mem_word(acc_addr);
                    pending     = 1'b0;
                end else begin
                    dcnt++;
                end
            end else if (bus_req) begin
                if (wcnt >= addr_dly) begin
                    bus_addr_ok = 1'b1;
                    wcnt        = 0;
                    acc_addr    = bus_addr;
                    acc_wr      = bus_wr;
                    acc_size    = bus_size;
                    acc_wdata   = bus_wdata;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Scoreboard: every done pulse consumes the oldest expected transaction.
    always @(negedge clk) begin
        if (inst_done || data_done) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", {62'd0, inst_done, data_done}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_port_is_inst", 64'(inst_done), 64'(mon_e.kind == 0));
                check("sb_bus_addr", acc_addr, mon_e.addr);
                check("sb_bus_wr", acc_wr, mon_e.kind == 2);
                check("sb_bus_size", acc_size, mon_e.size);
                if (mon_e.kind == 2)      check("sb_store_wdata", acc_wdata, mon_e.data);
                else if (mon_e.kind == 0) check("sb_inst_rdata", inst_rdata, mon_e.data);
                else                      check("sb_load_rdata", data_rdata, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request from posedge+1, hold until its done pulse, then drop it.
    task automatic do_txn(input int kind, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [1:0] sz);
        int budget;
        bit seen;
        sb.push_back(mk_exp(kind, a, wd, sz));
        if (kind == 0) begin
            inst_req  = 1'b1;
            inst_addr = a;
        end else begin
            data_req   = 1'b1;
            data_wr    = (kind == 2);
            data_addr  = a;
            data_size  = sz;
            data_wdata = wd;
        end
        budget = 0;
        seen   = 1'b0;
        while (!seen && budget < 40) begin
            @(negedge clk);
            budget++;
            seen = inst_done || data_done;
        end
        if (!seen) check("txn_timeout", 64'(seen), 64'd1);
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int  stall_bad, dd_cyc, ireq_cyc, req_cyc, unstable, done_n, mem_low;
        int  a_ok, b_req;
        bit  got_inst, armed, fired, b_done, got_ok;
        logic [AW-1:0] fa, fb;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_size_wr", {bus_size, bus_wr}, 0);
        check("rst_done", {inst_done, data_done}, 0);
        check("rst_stall", {stallreq_from_if, stallreq_from_mem}, 0);
        check("rst_perf", perf_txn, 0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- single fetch, minimum latency ----------------
        sb.push_back(mk_exp(0, 32'hBFC0_0000, '0, SZ_WORD));
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        @(negedge clk);
        check("f_c0_stall_if", stallreq_from_if, 1);
        check("f_c0_bus_req", bus_req, 0);
        @(negedge clk);
        check("f_c1_bus_req", bus_req, 1);
        check("f_c1_bus_addr", bus_addr, 32'hBFC0_0000);
        check("f_c1_stall_if", stallreq_from_if, 1);
        @(negedge clk);
        check("f_c2_inst_done", inst_done, 1);
        check("f_c2_inst_rdata", inst_rdata, 32'h3C08_0001);
        check("f_c2_stall_if", stallreq_from_if, 0);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        check("f_c3_no_done", inst_done, 0);
        check("f_perf", perf_txn, 1);
        tick();

        // ---------------- simultaneous fetch and load ----------------
        sb.push_back(mk_exp(1, 32'h8000_0010, '0, SZ_WORD));
        sb.push_back(mk_exp(0, 32'hBFC0_0004, '0, SZ_WORD));
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0004;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = SZ_WORD;
        data_addr = 32'h8000_0010;
        stall_bad = 0;
        dd_cyc    = -1;
        ireq_cyc  = -1;
        got_inst  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_req && bus_addr == 32'hBFC0_0004 && ireq_cyc < 0) ireq_cyc = c;
            if (data_done) dd_cyc = c;
            if (inst_done) begin
                got_inst = 1'b1;
                break;
            end
            if (!stallreq_from_if) stall_bad++;
            tick();
            if (dd_cyc >= 0) data_req = 1'b0;
        end
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        check("both_inst_done_seen", got_inst, 1);
        check("both_data_done_cycle", dd_cyc, 2);
        check("both_inst_bus_req_cycle", ireq_cyc, 4);
        check("both_stall_if_held", stall_bad, 0);

        // ---------------- store with delayed address accept ----------------
        addr_dly = 3;
        sb.push_back(mk_exp(2, 32'h8000_0004, 32'hDEAD_BEEF, SZ_WORD));
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = SZ_WORD;
        data_addr  = 32'h8000_0004;
        data_wdata = 32'hDEAD_BEEF;
        req_cyc  = 0;
        unstable = 0;
        done_n   = 0;
        mem_low  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_req) begin
                req_cyc++;
                if (bus_addr != 32'h8000_0004 || bus_wdata != 32'hDEAD_BEEF ||
                    !bus_wr || bus_size != SZ_WORD) unstable++;
            end
            if (data_done) begin
                done_n++;
                check("st_stall_mem_done_cycle", stallreq_from_mem, 0);
            end else if (data_req && !stallreq_from_mem) begin
                mem_low++;
            end
            tick();
            if (done_n > 0) data_req = 1'b0;
        end
        addr_dly = 0;
        check("st_bus_req_cycles", req_cyc, 4);
        check("st_bus_stable", unstable, 0);
        check("st_done_once", done_n, 1);
        check("st_stall_mem_held", mem_low, 0);

        // ---------------- flush during I_DATA ----------------
        data_dly = 2;
        fa = 32'hBFC0_0100;
        fb = 32'hBFC0_0200;
        sb.push_back(mk_exp(0, fb, '0, SZ_WORD));
        inst_req  = 1'b1;
        inst_addr = fa;
        a_ok   = -1;
        b_req  = -1;
        armed  = 1'b0;
        fired  = 1'b0;
        b_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (flush) check("fl_stall_if_low", stallreq_from_if, 0);
            if (bus_data_ok && a_ok < 0) begin
                a_ok = c;
                check("fl_no_inst_done", inst_done, 0);
            end
            if (bus_req && bus_addr == fb && b_req < 0) b_req = c;
            if (inst_done && a_ok >= 0 && c > a_ok) begin
                b_done = 1'b1;
                break;
            end
            if (bus_addr_ok && !fired) armed = 1'b1;
            tick();
            if (flush) begin
                flush = 1'b0;
            end else if (armed) begin
                flush     = 1'b1;
                inst_addr = fb;
                armed     = 1'b0;
                fired     = 1'b1;
            end
        end
        tick();
        inst_req = 1'b0;
        flush    = 1'b0;
        data_dly = 0;
        check("fl_refetch_done", b_done, 1);
        check("fl_refetch_after_idle", b_req - a_ok, 2);
        @(negedge clk);
        check("fl_perf", perf_txn, 6);
        tick();

        // ---------------- reset while in D_DATA ----------------
        data_dly   = 2;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = SZ_HALF;
        data_addr  = 32'h8000_0020;
        data_wdata = 32'h1234_5678;
        got_ok     = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_addr_ok) begin
                got_ok = 1'b1;
                break;
            end
        end
        check("rd_addr_accepted", got_ok, 1);
        tick();
        rst      = 1'b1;
        data_req = 1'b0;
        @(negedge clk);
        check("rd_rst_cycle_no_done", data_done, 0);
        tick();
        @(negedge clk);
        check("rd_bus_req", bus_req, 0);
        check("rd_bus_addr", bus_addr, 0);
        check("rd_bus_wdata", bus_wdata, 0);
        check("rd_bus_size_wr", {bus_size, bus_wr}, 0);
        check("rd_rdata", {inst_rdata, data_rdata}, 0);
        check("rd_stall", {stallreq_from_if, stallreq_from_mem}, 0);
        check("rd_perf", perf_txn, 0);
        tick();
        rst      = 1'b0;
        data_dly = 0;
        done_n   = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_done || inst_done) done_n++;
        end
        check("rd_no_late_done", done_n, 0);
        tick();

        // ---------------- mixed traffic ----------------
        for (int i = 0; i < 10; i++) begin
            int k;
            addr_dly = $urandom_range(0, 2);
            data_dly = $urandom_range(0, 2);
            k = $urandom_range(0, 2);
            do_txn(k, 32'h8000_0000 | ($urandom & 32'h0000_FFFC), $urandom,
                   2'($urandom_range(0, 2)));
        end
        addr_dly = 0;
        data_dly = 0;
        @(negedge clk);
        check("mix_perf", perf_txn, 10);

        // ---------------- counter wrap (preloaded near the top) ----------------
        force dut.txn_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.txn_cnt;
        @(negedge clk);
        check("wrap_preload", perf_txn, 16'hFFFE);
        tick();
        do_txn(1, 32'h8000_0040, '0, SZ_WORD);
        @(negedge clk);
        check("wrap_ffff", perf_txn, 16'hFFFF);
        tick();
        do_txn(2, 32'h8000_0044, 32'hCAFE_F00D, SZ_BYTE);
        @(negedge clk);
        check("wrap_zero", perf_txn, 16'h0000);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
